// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Four-entry store buffer between the processor's load/store unit and the
// data memory. Stores are queued and drained to memory in order, one per
// accepted write. Loads bypass the queue to memory when they cannot observe
// a buffered store.
//
// Optional feature (compile-time macro STORE_BUF_FWD_EN):
//   defined   : loads are looked up in the buffer. An exact match (same
//               address and size) is forwarded from the youngest match. A
//               partial overlap within the same doubleword stalls until the
//               overlapping stores have drained.
//   undefined : no lookup hardware; any load stalls while the buffer holds
//               anything.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   cpu_addr/cpu_wdata      processor address and right-aligned store data
//   cpu_size                RISC-V funct3 access size (0..6)
//   cpu_we / cpu_re         store / load request (never both high)
//   cpu_rdata               extended load result
//   cpu_stall               request not accepted this cycle
//   mem_addr/mem_wdata      memory address and write data
//   mem_size / mem_we       memory access size and write strobe
//   mem_ready               memory accepts the write this cycle
//   mem_rdata               combinational, already-extended memory load data
//   halt / drained          drain request / halt with empty buffer
// ---------------------------------------------------------------------------
module store_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    input  logic [2:0]  cpu_size,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [63:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [2:0]  mem_size,
    output logic        mem_we,
    input  logic        mem_ready,
    input  logic [63:0] mem_rdata,
    input  logic        halt,
    output logic        drained
);

    localparam int DEPTH = 4;

    logic [63:0] entry_addr [DEPTH];
    logic [63:0] entry_data [DEPTH];
    logic [1:0]  entry_size [DEPTH];

    logic [1:0]  head;
    logic [1:0]  tail;
    logic [2:0]  count;

    logic        buf_full;
    logic        buf_empty;
    logic        load_stall;
    logic        load_hit;
    logic [63:0] hit_data;
    logic        mem_load;
    logic        enq;
    logic        deq;

    assign buf_full  = (count == 3'd4);
    assign buf_empty = (count == 3'd0);

`ifdef STORE_BUF_FWD_EN
    // Sign-extend (sizes 0-3) or zero-extend (sizes 4-6) a right-aligned value.
    function automatic logic [63:0] extend_load(input logic [63:0] d, input logic [2:0] sz);
        case (sz)
            3'd0:    extend_load = {{56{d[7]}},  d[7:0]};
            3'd1:    extend_load = {{48{d[15]}}, d[15:0]};
            3'd2:    extend_load = {{32{d[31]}}, d[31:0]};
            3'd4:    extend_load = {56'd0, d[7:0]};
            3'd5:    extend_load = {48'd0, d[15:0]};
            3'd6:    extend_load = {32'd0, d[31:0]};
            default: extend_load = d;
        endcase
    endfunction

    // Walk occupied entries oldest to youngest so the last exact match wins.
    // Any same-doubleword entry that is not an exact match is a conflict,
    // which overrides forwarding entirely.
    always_comb begin
        logic       conflict;
        logic       match;
        logic [1:0] idx;
        conflict = 1'b0;
        match    = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + 2'(i);
            if ((3'(i) < count) && (entry_addr[idx][63:3] == cpu_addr[63:3])) begin
                if ((entry_addr[idx] == cpu_addr) && (entry_size[idx] == cpu_size[1:0])) begin
                    match    = 1'b1;
                    hit_data = extend_load(entry_data[idx], cpu_size);
                end else begin
                    conflict = 1'b1;
                end
            end
        end
        load_stall = cpu_re && conflict;
        load_hit   = cpu_re && match && !conflict;
    end
`else
    // Without forwarding a load may not pass any buffered store.
    assign load_stall = cpu_re && !buf_empty;
    assign load_hit   = 1'b0;
    assign hit_data   = '0;
`endif

    // A load that is neither stalled nor forwarded owns the memory port.
    assign mem_load = cpu_re && !load_stall && !load_hit;

    // No same-cycle enqueue into a full buffer, even if the head retires.
    assign enq = cpu_we && !buf_full;
    assign deq = mem_we && mem_ready;

    // Output mux. Everything is forced to zero while reset is asserted so the
    // outputs are quiet regardless of what the processor presents.
    always_comb begin
        cpu_rdata = '0;
        cpu_stall = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_size  = '0;
        mem_we    = 1'b0;
        drained   = 1'b0;
        if (rst_n) begin
            cpu_stall = (cpu_we && buf_full) || load_stall;
            drained   = halt && buf_empty;
            if (mem_load) begin
                mem_addr  = cpu_addr;
                mem_size  = cpu_size;
                cpu_rdata = mem_rdata;
            end else if (!buf_empty) begin
                mem_we    = 1'b1;
                mem_addr  = entry_addr[head];
                mem_wdata = entry_data[head];
                mem_size  = {1'b0, entry_size[head]};
            end
            if (load_hit) begin
                cpu_rdata = hit_data;
            end
        end
    end

    // Queue pointers and occupancy. Entry payloads are not reset: an entry is
    // only ever read while it lies inside the occupied head..tail window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 2'd1;
            end
            if (deq) begin
                head <= head + 2'd1;
            end
            count <= count + {2'b00, enq} - {2'b00, deq};
        end
    end

    always_ff @(posedge clk) begin
        if (enq && rst_n) begin
            entry_addr[tail] <= cpu_addr;
            entry_data[tail] <= cpu_wdata;
            entry_size[tail] <= cpu_size[1:0];
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//
// Self-checking bench for store_buffer. A queue of pending stores is the
// reference: expected outputs each cycle are derived from the queue contents
// and the current request. Directed scenarios run first, followed by a
// randomized phase. Builds with or without STORE_BUF_FWD_EN; the reference
// follows the same macro.
// ---------------------------------------------------------------------------
module tb_store_buffer;

    logic        clk;
    logic        rst_n;
    logic [63:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic [2:0]  cpu_size;
    logic        cpu_we;
    logic        cpu_re;
    logic [63:0] cpu_rdata;
    logic        cpu_stall;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [2:0]  mem_size;
    logic        mem_we;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        halt;
    logic        drained;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
    } store_t;

    store_t pending[$];

    // Expected values for the current cycle.
    logic        exp_stall;
    logic        exp_we;
    logic [63:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [2:0]  exp_size;
    logic [63:0] exp_rdata;
    logic        exp_drained;

    // Values seen at the last sampling point, for scenario-level checks.
    logic        obs_stall;
    logic        obs_we;
    logic [63:0] obs_addr;
    logic [63:0] obs_wdata;
    logic [2:0]  obs_size;
    logic [63:0] obs_rdata;
    logic        obs_drained;
    logic [63:0] drv_rdata;

    store_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_size  (cpu_size),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_size  (mem_size),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .halt      (halt),
        .drained   (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Width-agnostic extension: mask to the access width, then fill upper
    // bits with the top data bit for the signed encodings.
    function automatic logic [63:0] extendRef(input logic [63:0] d, input logic [2:0] sz);
        int          nbits;
        logic [63:0] mask;
        logic [63:0] v;
        nbits = 8 << sz[1:0];
        if (nbits >= 64) return d;
        mask = (64'd1 << nbits) - 64'd1;
        v    = d & mask;
        if (!sz[2] && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic modelEval();
        logic        conflict;
        logic        hit;
        logic        load_blocked;
        logic        mem_load;
        logic [63:0] fwd;
        conflict = 1'b0;
        hit      = 1'b0;
        fwd      = '0;
`ifdef STORE_BUF_FWD_EN
        foreach (pending[i]) begin
            if (pending[i].addr[63:3] == cpu_addr[63:3]) begin
                if (pending[i].addr == cpu_addr && pending[i].size == cpu_size[1:0]) begin
                    hit = 1'b1;
                    fwd = extendRef(pending[i].data, cpu_size);
                end else begin
                    conflict = 1'b1;
                end
            end
        end
        load_blocked = cpu_re && conflict;
        hit          = cpu_re && hit && !conflict;
`else
        load_blocked = cpu_re && (pending.size() != 0);
`endif
        mem_load    = cpu_re && !load_blocked && !hit;
        exp_stall   = (cpu_we && pending.size() == 4) || load_blocked;
        exp_drained = halt && (pending.size() == 0);
        exp_we      = 1'b0;
        exp_addr    = '0;
        exp_wdata   = '0;
        exp_size    = '0;
        exp_rdata   = hit ? fwd : '0;
        if (mem_load) begin
            exp_addr  = cpu_addr;
            exp_size  = cpu_size;
            exp_rdata = mem_rdata;
        end else if (pending.size() != 0) begin
            exp_we    = 1'b1;
            exp_addr  = pending[0].addr;
            exp_wdata = pending[0].data;
            exp_size  = {1'b0, pending[0].size};
        end
    endtask

    // One clock cycle: drive the request, check at the falling edge, then
    // advance the reference queue on the rising edge.
    task automatic applyStimulus(input logic we, input logic re, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [2:0] size,
                                 input logic ready);
        logic   do_enq;
        logic   do_deq;
        store_t e;
        cpu_we    = we;
        cpu_re    = re;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_size  = size;
        mem_ready = ready;
        drv_rdata = {$urandom(), $urandom()};
        mem_rdata = drv_rdata;
        @(negedge clk);
        modelEval();
        obs_stall   = cpu_stall;
        obs_we      = mem_we;
        obs_addr    = mem_addr;
        obs_wdata   = mem_wdata;
        obs_size    = mem_size;
        obs_rdata   = cpu_rdata;
        obs_drained = drained;
        checkOutput("cpu_stall", 64'(cpu_stall), 64'(exp_stall));
        checkOutput("mem_we",    64'(mem_we),    64'(exp_we));
        checkOutput("mem_addr",  mem_addr,       exp_addr);
        checkOutput("mem_wdata", mem_wdata,      exp_wdata);
        checkOutput("mem_size",  64'(mem_size),  64'(exp_size));
        checkOutput("drained",   64'(drained),   64'(exp_drained));
        if (re && !exp_stall) checkOutput("cpu_rdata", cpu_rdata, exp_rdata);
        do_enq = we && !exp_stall;
        do_deq = exp_we && ready;
        @(posedge clk);
        if (do_deq) void'(pending.pop_front());
        if (do_enq) begin
            e.addr = addr;
            e.data = wdata;
            e.size = size[1:0];
            pending.push_back(e);
        end
        #1;
    endtask

    task automatic idleCycle(input logic ready);
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 3'd0, ready);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must drop at once.
    task automatic pulseReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mem_we",   64'(mem_we),    64'd0);
        checkOutput("rst_stall",    64'(cpu_stall), 64'd0);
        checkOutput("rst_drained",  64'(drained),   64'd0);
        checkOutput("rst_mem_addr", mem_addr,       64'd0);
        checkOutput("rst_mem_data", mem_wdata,      64'd0);
        checkOutput("rst_rdata",    cpu_rdata,      64'd0);
        pending.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wcount;
        int op;
        rst_n     = 1'b0;
        cpu_we    = 1'b0;
        cpu_re    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_size  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        halt      = 1'b0;

        // Reset state
        #12;
        checkOutput("init_mem_we",   64'(mem_we),    64'd0);
        checkOutput("init_stall",    64'(cpu_stall), 64'd0);
        checkOutput("init_drained",  64'(drained),   64'd0);
        checkOutput("init_mem_addr", mem_addr,       64'd0);
        checkOutput("init_rdata",    cpu_rdata,      64'd0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single doubleword store drains one cycle after enqueue
        applyStimulus(1'b1, 1'b0, 64'h100, 64'h1122334455667788, 3'd3, 1'b1);
        checkOutput("sd_enq_no_we", 64'(obs_we), 64'd0);
        idleCycle(1'b1);
        checkOutput("sd_we",    64'(obs_we),   64'd1);
        checkOutput("sd_addr",  obs_addr,      64'h100);
        checkOutput("sd_size",  64'(obs_size), 64'd3);
        checkOutput("sd_data",  obs_wdata,     64'h1122334455667788);
        idleCycle(1'b1);
        checkOutput("sd_once",  64'(obs_we),   64'd0);
        checkOutput("idle_addr", obs_addr,     64'd0);

        // Fill to capacity with memory not ready; fifth store stalls
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h1000 + 64'(i * 8), 64'(i + 1), 3'd3, 1'b0);
            checkOutput("fill_accept", 64'(obs_stall), 64'd0);
        end
        applyStimulus(1'b1, 1'b0, 64'h1020, 64'h55, 3'd3, 1'b0);
        checkOutput("full_stall_a", 64'(obs_stall), 64'd1);
        applyStimulus(1'b1, 1'b0, 64'h1020, 64'h55, 3'd3, 1'b0);
        checkOutput("full_stall_b", 64'(obs_stall), 64'd1);
        applyStimulus(1'b1, 1'b0, 64'h1020, 64'h55, 3'd3, 1'b1);
        checkOutput("full_stall_retire", 64'(obs_stall), 64'd1);
        checkOutput("full_head_addr", obs_addr, 64'h1000);
        applyStimulus(1'b1, 1'b0, 64'h1020, 64'h55, 3'd3, 1'b1);
        checkOutput("full_accept_after", 64'(obs_stall), 64'd0);
        for (int i = 0; i < 10 && pending.size() != 0; i++) idleCycle(1'b1);
        idleCycle(1'b1);
        checkOutput("fill_drained_we", 64'(obs_we), 64'd0);

`ifdef STORE_BUF_FWD_EN
        // Forwarding of an exact word match, signed and unsigned
        applyStimulus(1'b1, 1'b0, 64'h200, 64'h80000001, 3'd2, 1'b0);
        applyStimulus(1'b0, 1'b1, 64'h200, 64'd0, 3'd2, 1'b0);
        checkOutput("lw_fwd_stall", 64'(obs_stall), 64'd0);
        checkOutput("lw_fwd_data",  obs_rdata, 64'hFFFFFFFF80000001);
        checkOutput("lw_fwd_drain", 64'(obs_we), 64'd1);
        applyStimulus(1'b0, 1'b1, 64'h200, 64'd0, 3'd6, 1'b0);
        checkOutput("lwu_fwd_data", obs_rdata, 64'h0000000080000001);

        // Partial overlap stalls until the overlapping byte store retires
        applyStimulus(1'b1, 1'b0, 64'h301, 64'hAB, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 64'h300, 64'd0, 3'd3, 1'b0);
        checkOutput("ld_conflict_stall", 64'(obs_stall), 64'd1);
        wcount = 0;
        do begin
            applyStimulus(1'b0, 1'b1, 64'h300, 64'd0, 3'd3, 1'b1);
            wcount++;
        end while (obs_stall && wcount < 8);
        checkOutput("ld_conflict_cycles", 64'(wcount), 64'd3);
        checkOutput("ld_conflict_rdata",  obs_rdata, drv_rdata);
        checkOutput("ld_conflict_maddr",  obs_addr,  64'h300);
`else
        // Any load waits for an empty buffer
        applyStimulus(1'b1, 1'b0, 64'h500, 64'h77, 3'd3, 1'b0);
        applyStimulus(1'b0, 1'b1, 64'h500, 64'd0, 3'd3, 1'b0);
        checkOutput("ld_nofwd_stall_a", 64'(obs_stall), 64'd1);
        applyStimulus(1'b0, 1'b1, 64'h500, 64'd0, 3'd3, 1'b1);
        checkOutput("ld_nofwd_stall_b", 64'(obs_stall), 64'd1);
        checkOutput("ld_nofwd_drain",   64'(obs_we),    64'd1);
        applyStimulus(1'b0, 1'b1, 64'h500, 64'd0, 3'd3, 1'b1);
        checkOutput("ld_nofwd_done",    64'(obs_stall), 64'd0);
        checkOutput("ld_nofwd_rdata",   obs_rdata, drv_rdata);
        checkOutput("ld_nofwd_maddr",   obs_addr,  64'h500);
`endif
        for (int i = 0; i < 10 && pending.size() != 0; i++) idleCycle(1'b1);

        // Halt drains three stores, then reports drained
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h2000 + 64'(i * 8), 64'(i + 100), 3'd3, 1'b0);
        end
        halt   = 1'b1;
        wcount = 0;
        for (int i = 0; i < 10; i++) begin
            idleCycle(1'b1);
            if (obs_we) wcount++;
            if (obs_drained) break;
        end
        checkOutput("halt_we_count", 64'(wcount), 64'd3);
        checkOutput("halt_drained",  64'(obs_drained), 64'd1);

        // Reset in the middle of a drain discards the remaining stores
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h3000 + 64'(i * 8), 64'(i + 200), 3'd3, 1'b0);
        end
        idleCycle(1'b1);
        checkOutput("mid_drain_we", 64'(obs_we), 64'd1);
        mem_ready = 1'b1;
        pulseReset();
        idleCycle(1'b1);
        checkOutput("post_rst_we",      64'(obs_we),      64'd0);
        checkOutput("post_rst_drained", 64'(obs_drained), 64'd1);
        idleCycle(1'b1);
        halt = 1'b0;

        // Randomized traffic over a small address window to provoke matches
        for (int n = 0; n < 600; n++) begin
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 31) == 0) halt = ~halt;
            if (op == 1) begin
                applyStimulus(1'b1, 1'b0, 64'h4000 + 64'($urandom_range(0, 23)),
                              {$urandom(), $urandom()}, 3'($urandom_range(0, 3)),
                              $urandom_range(0, 2) != 0);
            end else if (op == 2) begin
                applyStimulus(1'b0, 1'b1, 64'h4000 + 64'($urandom_range(0, 23)),
                              64'd0, 3'($urandom_range(0, 6)),
                              $urandom_range(0, 2) != 0);
            end else begin
                idleCycle($urandom_range(0, 2) != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
